mips_regfile_dump_reader: RTL and testbench
===========================================

// Module: mips_regfile_dump_reader
// PURPOSE
//  Debug read-out engine for the single-cycle MIPS register file: the read-side counterpart of the register write path.
//  On a start pulse it walks the register file through read port 0, address 0 (or 1) up to NUM_REGS-1.
//  Each register is streamed out on a valid/ready handshake with its address, plus a running XOR checksum.
//  Sits beside the datapath; shares read port 0 through a debug mux controlled by busy_o.
// PARAMETERS
//  ADDR_W     5   register address width
//  DATA_W     32  register data width
//  NUM_REGS   32  registers walked; last address = NUM_REGS-1
//  SKIP_ZERO  0   1: start at address 1 ($zero not dumped)
// PORTS
//  clk           in   1       rising-edge clock
//  rst_n         in   1       asynchronous active-low reset
//  start_i       in   1       start dump; sampled in IDLE only
//  abort_i       in   1       cancel dump; any non-IDLE state
//  rd_addr0_o    out  ADDR_W  address to register file read port 0
//  rd_data0_i    in   DATA_W  combinational read data for rd_addr0_o
//  dump_valid_o  out  1       dump word valid
//  dump_ready_i  in   1       consumer ready
//  dump_addr_o   out  ADDR_W  register index of dump_data_o
//  dump_data_o   out  DATA_W  register contents
//  dump_last_o   out  1       high with valid on final word
//  busy_o        out  1       high in FETCH/SEND (owns read port 0)
//  done_o        out  1       one-cycle pulse after last handshake
//  checksum_o    out  DATA_W  XOR of all handshaked words; stable outside busy
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; all outputs 0; checksum_o=0; rd_addr0_o=0.
//  FSM states: IDLE, FETCH, SEND, DONE.
//   IDLE : start_i=1 -> FETCH; rd_addr0_o<=first (0, or 1 if SKIP_ZERO); checksum<=0.
//   FETCH: register file read is combinational.
//          Capture dump_data_o<=rd_data0_i, dump_addr_o<=rd_addr0_o.
//          Set dump_valid_o<=1; dump_last_o<=(rd_addr0_o==NUM_REGS-1); -> SEND.
//   SEND : hold data/addr/last stable while valid && !ready.
//          On valid&&ready: checksum^=dump_data_o; valid<=0.
//          If last -> DONE; else rd_addr0_o<=rd_addr0_o+1 -> FETCH.
//   DONE : done_o=1 for exactly this cycle -> IDLE.
//  Latency: start sampled at edge N; first valid from edge N+2.
//   Max throughput 1 word per 2 cycles; full dump (ready tied 1) = 2*words+1 cycles start-to-done.
//  Words: NUM_REGS (SKIP_ZERO=0) or NUM_REGS-1 (SKIP_ZERO=1).
//   Address increments, never wraps; last word at NUM_REGS-1.
//  start_i in FETCH/SEND/DONE: ignored.
//  abort_i in FETCH/SEND/DONE: next edge -> IDLE; valid, last, busy cleared; no done_o; checksum holds partial value.
//   abort has priority over a same-cycle handshake; that word does not count.
//  Concurrent register writes: the dumped value is whatever read port 0 returns at the FETCH edge; no snapshot.
//  Reset mid-dump: immediate return to reset values; a new start is required.
//  valid never deasserts without handshake except by abort/reset.
// TESTING
//  1 Preload reg k=k*3, ready=1, start -> 32 words addr 0..31, data 0..93, last on 31, done_o at cycle 65, checksum=XOR(k*3).
//  2 SKIP_ZERO=1, same preload -> 31 words addr 1..31, first data 3, done after 63 cycles.
//  3 Random ready (50%) -> data/addr stable while stalled, no dropped or duplicated words, checksum matches model.
//  4 abort_i at 10th word while ready=0 -> IDLE next edge, valid=0, no done_o; restart dumps from addr 0.
//  5 start_i pulsed repeatedly mid-dump -> ignored, single 32-word sequence.
//  6 rst_n low during SEND at addr 7 -> outputs 0 immediately; after release no activity until start.

Source files
------------

// File: rtl/mips_regfile_dump_reader.sv
// Debug read-out engine: walks the register file through read port 0 and streams each
// register out on a valid/ready handshake with its index and a running XOR checksum.
module mips_regfile_dump_reader #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_REGS  = 32,
  parameter bit          SKIP_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  output logic [ADDR_W-1:0] rd_addr0_o,
  input  logic [DATA_W-1:0] rd_data0_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [ADDR_W-1:0] dump_addr_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              dump_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] checksum_o
);

  typedef enum logic [1:0] {StIdle, StFetch, StSend, StDone} state_e;

  localparam logic [ADDR_W-1:0] FirstAddr = SKIP_ZERO ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(NUM_REGS - 1);

  state_e state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rd_addr0_o   <= '0;
      dump_valid_o <= 1'b0;
      dump_addr_o  <= '0;
      dump_data_o  <= '0;
      dump_last_o  <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      checksum_o   <= '0;
    end else begin
      done_o <= 1'b0;
      // Abort wins over a same-cycle handshake, so the pending word never reaches the checksum.
      if (abort_i && (state_q != StIdle)) begin
        state_q      <= StIdle;
        dump_valid_o <= 1'b0;
        dump_last_o  <= 1'b0;
        busy_o       <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_i) begin
              state_q    <= StFetch;
              rd_addr0_o <= FirstAddr;
              checksum_o <= '0;
              busy_o     <= 1'b1;
            end
          end
          StFetch: begin
            dump_data_o  <= rd_data0_i;
            dump_addr_o  <= rd_addr0_o;
            dump_valid_o <= 1'b1;
            dump_last_o  <= (rd_addr0_o == LastAddr);
            state_q      <= StSend;
          end
          StSend: begin
            if (dump_ready_i) begin
              checksum_o   <= checksum_o ^ dump_data_o;
              dump_valid_o <= 1'b0;
              if (dump_last_o) begin
                dump_last_o <= 1'b0;
                busy_o      <= 1'b0;
                done_o      <= 1'b1;
                state_q     <= StDone;
              end else begin
                rd_addr0_o <= rd_addr0_o + ADDR_W'(1);
                state_q    <= StFetch;
              end
            end
          end
          StDone: begin
            state_q <= StIdle;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mips_regfile_dump_reader.sv
// Randomised bench for mips_regfile_dump_reader: a behavioural model of the dump sequence
// scores every handshaked word, the checksum, done timing, abort and reset behaviour.
module tb_mips_regfile_dump_reader;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] regs [NUM_REGS];

  int n_checks = 0;
  int n_fail   = 0;

  // DUT A: dumps from address 0
  logic              start_a, abort_a, ready_a, valid_a, last_a, busy_a, done_a;
  logic [ADDR_W-1:0] rd_addr0_a, addr_a;
  logic [DATA_W-1:0] rd_data0_a, data_a, csum_a;

  // DUT B: $zero skipped
  logic              start_b, abort_b, ready_b, valid_b, last_b, busy_b, done_b;
  logic [ADDR_W-1:0] rd_addr0_b, addr_b;
  logic [DATA_W-1:0] rd_data0_b, data_b, csum_b;

  assign rd_data0_a = regs[rd_addr0_a];
  assign rd_data0_b = regs[rd_addr0_b];

  mips_regfile_dump_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SKIP_ZERO(1'b0)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .abort_i(abort_a),
    .rd_addr0_o(rd_addr0_a), .rd_data0_i(rd_data0_a),
    .dump_valid_o(valid_a), .dump_ready_i(ready_a), .dump_addr_o(addr_a),
    .dump_data_o(data_a), .dump_last_o(last_a), .busy_o(busy_a), .done_o(done_a),
    .checksum_o(csum_a)
  );

  mips_regfile_dump_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SKIP_ZERO(1'b1)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .abort_i(abort_b),
    .rd_addr0_o(rd_addr0_b), .rd_data0_i(rd_data0_b),
    .dump_valid_o(valid_b), .dump_ready_i(ready_b), .dump_addr_o(addr_b),
    .dump_data_o(data_b), .dump_last_o(last_b), .busy_o(busy_b), .done_o(done_b),
    .checksum_o(csum_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload_linear();
    for (int k = 0; k < int'(NUM_REGS); k++) regs[k] = 32'(k * 3);
  endtask

  task automatic preload_random();
    for (int k = 0; k < int'(NUM_REGS); k++) regs[k] = $urandom;
  endtask

  // Full dump on DUT A; ready_pct is the chance of ready per cycle, abort_word aborts while
  // that many words have been accepted (-1: never), pulse_start toggles start mid-dump.
  task automatic dump_a(input int ready_pct, input int abort_word, input bit pulse_start);
    int                exp_addr = 0;
    int                words    = 0;
    int                cyc      = 0;
    int                done_cyc = -1;
    logic [DATA_W-1:0] exp_sum  = '0;
    bit                stalled  = 1'b0;
    logic [ADDR_W-1:0] h_addr   = '0;
    logic [DATA_W-1:0] h_data   = '0;
    logic              h_last   = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    abort_a = 1'b0;
    ready_a = 1'b0;
    @(posedge clk);
    cyc = 1;
    while (cyc < 400) begin
      @(negedge clk);
      if (done_a) begin
        done_cyc = cyc;
        start_a  = 1'b0;
        break;
      end
      start_a = pulse_start ? 1'($urandom_range(1)) : 1'b0;
      if (stalled) begin
        check_eq("stall_valid", 32'(valid_a), 32'd1);
        check_eq("stall_addr", 32'(addr_a), 32'(h_addr));
        check_eq("stall_data", data_a, h_data);
        check_eq("stall_last", 32'(last_a), 32'(h_last));
      end
      ready_a = ($urandom_range(99) < 32'(ready_pct));
      if (valid_a && (words == abort_word)) begin
        ready_a = 1'b0;
        abort_a = 1'b1;
        start_a = 1'b0;
        @(posedge clk);
        #1;
        abort_a = 1'b0;
        check_eq("abort_valid", 32'(valid_a), 32'd0);
        check_eq("abort_busy", 32'(busy_a), 32'd0);
        check_eq("abort_last", 32'(last_a), 32'd0);
        check_eq("abort_csum", csum_a, exp_sum);
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check_eq("abort_no_done", 32'(done_a | valid_a | busy_a), 32'd0);
        end
        return;
      end
      if (valid_a && ready_a) begin
        check_eq("word_addr", 32'(addr_a), 32'(exp_addr));
        check_eq("word_data", data_a, regs[exp_addr]);
        check_eq("word_last", 32'(last_a), 32'(exp_addr == int'(NUM_REGS) - 1));
        exp_sum ^= regs[exp_addr];
        exp_addr++;
        words++;
      end
      stalled = valid_a && !ready_a;
      h_addr  = addr_a;
      h_data  = data_a;
      h_last  = last_a;
      @(posedge clk);
      cyc++;
    end
    check_eq("done_seen", 32'(done_cyc > 0), 32'd1);
    check_eq("word_count", 32'(words), 32'(NUM_REGS));
    check_eq("checksum", csum_a, exp_sum);
    check_eq("busy_at_done", 32'(busy_a), 32'd0);
    if (ready_pct >= 100) check_eq("done_cycle", 32'(done_cyc), 32'(2 * NUM_REGS + 1));
    ready_a = 1'b0;
    @(negedge clk);
    check_eq("done_pulse_width", 32'(done_a), 32'd0);
    check_eq("checksum_hold", csum_a, exp_sum);
  endtask

  // DUT B with ready tied high: words from address 1, done after 2*31+1 cycles.
  task automatic dump_b();
    int                exp_addr = 1;
    int                words    = 0;
    int                cyc      = 0;
    int                done_cyc = -1;
    logic [DATA_W-1:0] exp_sum  = '0;
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    cyc = 1;
    while (cyc < 200) begin
      @(negedge clk);
      start_b = 1'b0;
      if (done_b) begin
        done_cyc = cyc;
        break;
      end
      if (valid_b) begin
        check_eq("b_addr", 32'(addr_b), 32'(exp_addr));
        check_eq("b_data", data_b, regs[exp_addr]);
        exp_sum ^= regs[exp_addr];
        exp_addr++;
        words++;
      end
      @(posedge clk);
      cyc++;
    end
    check_eq("b_done_cycle", 32'(done_cyc), 32'(2 * (NUM_REGS - 1) + 1));
    check_eq("b_word_count", 32'(words), 32'(NUM_REGS - 1));
    check_eq("b_checksum", csum_b, exp_sum);
  endtask

  task automatic check_a_reset_values(input string tag);
    check_eq({tag, "_valid"}, 32'(valid_a), 32'd0);
    check_eq({tag, "_last"}, 32'(last_a), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy_a), 32'd0);
    check_eq({tag, "_done"}, 32'(done_a), 32'd0);
    check_eq({tag, "_addr"}, 32'(addr_a), 32'd0);
    check_eq({tag, "_data"}, data_a, 32'd0);
    check_eq({tag, "_csum"}, csum_a, 32'd0);
    check_eq({tag, "_rdaddr"}, 32'(rd_addr0_a), 32'd0);
  endtask

  initial begin
    int  guard;
    bit  found;
    rst_n   = 1'b0;
    start_a = 1'b0;
    abort_a = 1'b0;
    ready_a = 1'b0;
    start_b = 1'b0;
    abort_b = 1'b0;
    ready_b = 1'b1;
    preload_linear();
    repeat (3) @(posedge clk);
    #1;
    check_a_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    dump_a(100, -1, 1'b0);
    dump_b();

    preload_random();
    dump_a(50, -1, 1'b0);
    dump_a(50, -1, 1'b0);

    dump_a(50, 9, 1'b0);
    dump_a(100, -1, 1'b0);

    preload_linear();
    dump_a(70, -1, 1'b1);

    // Reset while word 7 is stalled in SEND
    @(negedge clk);
    start_a = 1'b1;
    ready_a = 1'b1;
    found   = 1'b0;
    guard   = 0;
    while (guard < 100) begin
      @(negedge clk);
      start_a = 1'b0;
      if (valid_a && (addr_a == ADDR_W'(7))) begin
        found = 1'b1;
        break;
      end
      guard++;
    end
    check_eq("reach_addr7", 32'(found), 32'd1);
    ready_a = 1'b0;
    rst_n   = 1'b0;
    #1;
    check_a_reset_values("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("post_reset_idle", 32'(valid_a | busy_a | done_a), 32'd0);
    end
    dump_a(100, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
